// File: rtl/signal_stats.sv
// signal_stats: streaming frame statistics (average, minimum, maximum).
// Accumulates SAMPLES unsigned samples per frame, then runs a restoring
// divider (one quotient bit per cycle, SUM_W cycles) to produce the average.
// Optional build macro SIGNAL_STATS_ROUND_EN selects round-half-up averaging
// (dividend biased by SAMPLES/2); without it the average truncates.
module signal_stats #(
   parameter int unsigned DATA_W  = 12,
   parameter int unsigned SAMPLES = 80
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              clear_i,
   output logic [DATA_W-1:0] avg_o,
   output logic [DATA_W-1:0] min_o,
   output logic [DATA_W-1:0] max_o,
   output logic              out_valid_o,
   output logic              busy_o
);

   // SAMPLES * (2^DATA_W - 1) < 2^SUM_W, so the accumulator never wraps.
   localparam int unsigned SUM_W = DATA_W + $clog2(SAMPLES);
   localparam int unsigned CNT_W = $clog2(SAMPLES);
   localparam int unsigned BIT_W = $clog2(SUM_W);

   localparam logic [SUM_W-1:0] Divisor  = SUM_W'(SAMPLES);
   localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(SAMPLES - 1);
   localparam logic [BIT_W-1:0] LastBit  = BIT_W'(SUM_W - 1);
`ifdef SIGNAL_STATS_ROUND_EN
   localparam logic [SUM_W-1:0] RoundAdd = SUM_W'(SAMPLES / 2);
`endif

   typedef enum logic [0:0] {
      StAcc,
      StDiv
   } state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [SUM_W-1:0]  sum_q;
   logic [DATA_W-1:0] cur_min_q;
   logic [DATA_W-1:0] cur_max_q;
   // quo_q starts as the dividend; dividend bits shift out of the top into
   // the remainder while quotient bits shift in at the bottom.
   logic [SUM_W-1:0]  quo_q;
   logic [SUM_W-1:0]  rem_q;
   logic [BIT_W-1:0]  bit_q;
   logic [DATA_W-1:0] avg_q;
   logic [DATA_W-1:0] min_q;
   logic [DATA_W-1:0] max_q;
   logic              out_valid_q;

   logic              first_smp;
   logic [SUM_W-1:0]  sum_d;
   logic [DATA_W-1:0] cur_min_d;
   logic [DATA_W-1:0] cur_max_d;
   logic [SUM_W-1:0]  dividend_d;
   logic [SUM_W:0]    rem_shift;
   logic              q_bit;
   logic [SUM_W-1:0]  rem_d;
   logic [SUM_W-1:0]  quo_d;

   // Accumulator and extreme-value next-state for the sample offered this cycle.
   always_comb begin
      first_smp = (cnt_q == '0);
      sum_d     = first_smp ? SUM_W'(in_data_i) : sum_q + SUM_W'(in_data_i);
      cur_min_d = (first_smp || (in_data_i < cur_min_q)) ? in_data_i : cur_min_q;
      cur_max_d = (first_smp || (in_data_i > cur_max_q)) ? in_data_i : cur_max_q;
`ifdef SIGNAL_STATS_ROUND_EN
      dividend_d = sum_d + RoundAdd;
`else
      dividend_d = sum_d;
`endif
   end

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_shift = {rem_q, quo_q[SUM_W-1]};
      q_bit     = (rem_shift >= {1'b0, Divisor});
      rem_d     = q_bit ? (rem_shift[SUM_W-1:0] - Divisor) : rem_shift[SUM_W-1:0];
      quo_d     = {quo_q[SUM_W-2:0], q_bit};
   end

   // Frame FSM, accumulator, divider and registered results.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StAcc;
         cnt_q       <= '0;
         sum_q       <= '0;
         cur_min_q   <= '0;
         cur_max_q   <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         bit_q       <= '0;
         avg_q       <= '0;
         min_q       <= '0;
         max_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            StAcc: begin
               if (clear_i) begin
                  // Partial frame discarded; a sample offered now is dropped.
                  cnt_q <= '0;
               end else if (in_valid_i) begin
                  sum_q     <= sum_d;
                  cur_min_q <= cur_min_d;
                  cur_max_q <= cur_max_d;
                  if (cnt_q == LastCnt) begin
                     // cur_min_q/cur_max_q stay frozen while dividing.
                     quo_q   <= dividend_d;
                     rem_q   <= '0;
                     bit_q   <= LastBit;
                     cnt_q   <= '0;
                     state_q <= StDiv;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            StDiv: begin
               if (clear_i) begin
                  state_q <= StAcc;
               end else begin
                  quo_q <= quo_d;
                  rem_q <= rem_d;
                  bit_q <= bit_q - 1'b1;
                  if (bit_q == '0) begin
                     // Upper quotient bits are always zero by the width rule.
                     avg_q       <= quo_d[DATA_W-1:0];
                     min_q       <= cur_min_q;
                     max_q       <= cur_max_q;
                     out_valid_q <= 1'b1;
                     state_q     <= StAcc;
                  end
               end
            end
            default: state_q <= StAcc;
         endcase
      end
   end

   assign in_ready_o  = (state_q == StAcc);
   assign busy_o      = (state_q == StDiv);
   assign avg_o       = avg_q;
   assign min_o       = min_q;
   assign max_o       = max_q;
   assign out_valid_o = out_valid_q;

`ifndef SYNTHESIS
   // A result pulse always coincides with the block being ready again.
   a_ov_ready : assert property (@(posedge clk_i) disable iff (!rst_ni)
      out_valid_q |-> (state_q == StAcc));
   // The divider never runs longer than SUM_W steps.
   a_bit_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == StDiv) |-> (bit_q <= LastBit));
`endif

endmodule

// File: doc/signal_stats.md
Name: signal_stats

Overview:
- Streaming statistics engine for the scope acquisition path: consumes one sample per handshake, accumulates a frame of SAMPLES samples, then reports the frame average, minimum and maximum.
- Generalised in sample width and frame depth; sum width is derived so the accumulator cannot overflow.
- The average uses a sequential restoring divider, so no wide combinational divide is required.
- Sits between the ADC sample buffer and the on-screen measurement overlay.

Parameters:
- DATA_W, 12, sample width in bits (unsigned).
- SAMPLES, 80, samples per frame; legal range 2..65535.
- SUM_W, DATA_W+$clog2(SAMPLES), accumulator/dividend width; localparam, not overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  DATA_W  sample value, unsigned.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a sample.
- clear  in  1  abort the current frame and discard partial results.
- avg  out  DATA_W  frame average.
- min  out  DATA_W  frame minimum.
- max  out  DATA_W  frame maximum.
- out_valid  out  1  one-cycle pulse when avg/min/max update.
- busy  out  1  high while the divider runs.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low. All state updates on posedge clk only.
- Reset (rst_n=0 at a posedge), all values 0 unless stated:
  - avg, min, max, out_valid, busy, accumulator, sample counter.
  - state=ACC; in_ready=1 in the first cycle after reset is released.
  - Reset mid-frame or mid-divide discards everything.
- States:
  - ACC: in_ready=1, busy=0. A sample is accepted when in_valid&&in_ready.
    - First sample of a frame (cnt==0): sum=in_data, cur_min=in_data, cur_max=in_data.
    - Later samples: sum+=in_data; cur_min/cur_max updated with strict < / >, so equal values do not change them.
    - On accepting sample number SAMPLES (cnt==SAMPLES-1): load divider (dividend=sum including this sample, quotient/remainder cleared, bit counter=SUM_W-1), latch cur_min/cur_max, cnt=0, go to DIV.
  - DIV: in_ready=0, busy=1. in_valid is ignored (the sample is not consumed; the upstream source holds it).
    - One restoring-division step per cycle: SUM_W cycles total, divisor=SAMPLES constant.
    - On the final step: avg=quotient[DATA_W-1:0], min/max from the latched values, out_valid=1 for the next cycle, state=ACC.
- Latency: with the last sample accepted at edge E, out_valid is high in the cycle after edge E+SUM_W. For defaults SUM_W=19, so 19 cycles. in_ready returns high in the same cycle out_valid pulses.
- Outputs hold their values between out_valid pulses.
- Width rule: sum ≤ SAMPLES·(2^DATA_W−1) < 2^SUM_W, so the accumulator never wraps. Quotient always fits in DATA_W; upper quotient bits are guaranteed 0.
- Average truncates toward zero when the rounding option is absent.
- clear:
  - In ACC: cnt=0 and the partial frame is discarded. A sample offered in the same cycle as clear is dropped, not counted.
  - In DIV: aborts the division, no out_valid, state=ACC.
  - avg/min/max keep the last completed values.
  - clear has priority over sample acceptance. rst_n has priority over clear.
- Back-to-back frames: the next frame's first sample is accepted in the out_valid cycle.

Optional Feature:
- Macro SIGNAL_STATS_ROUND_EN.
- When defined: dividend = sum + SAMPLES/2 (integer), giving round-half-up averaging. The width still fits SUM_W, and the result saturates naturally at 2^DATA_W−1.
- When undefined: dividend = sum, truncating average.
- Latency is identical in both builds.

Test Plan:
- Reset, then 80 samples of 100 with in_valid held high -> out_valid pulses once, 19 cycles after the last accept; avg=100, min=100, max=100; busy high exactly 19 cycles.
- Ramp 0..79 -> sum 3160; avg=39 (40 with SIGNAL_STATS_ROUND_EN); min=0, max=79.
- 80 samples of 4095 -> avg=4095, min=4095, max=4095 in both builds (no accumulator overflow).
- in_valid held high during DIV, then 80 random samples with random in_valid gaps -> no sample consumed while in_ready=0; results match the reference model; back-to-back frame accepted in the out_valid cycle.
- 40 samples, then clear, then 80 samples of 7 -> avg=7, min=7, max=7; the first 40 samples are ignored; clear asserted mid-DIV -> no out_valid, outputs unchanged.
- rst_n low for 1 cycle mid-frame and again mid-DIV -> all outputs 0, no out_valid; the next full frame reports correctly.
